// File: rtl/prefix_postprocess_seq.sv
// Iterative Kogge-Stone postprocess: consumes G/P/Cin, evaluates one prefix
// level per clock, then forms Sum/Cout behind valid/ready handshakes.
module prefix_postprocess_seq #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] P,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             gp_err
);

  localparam int KW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] g_r, p_r, hsum_r, sum_r;
  logic             cin_r, cout_r, gp_err_r;
  logic [WIDTH-1:0] g_lvl, p_lvl;
  logic             accept, last_lvl;

  // One Kogge-Stone level at distance 2^lvl; bits below the distance pass through.
  function automatic logic [2*WIDTH-1:0] prefix_level(input logic [WIDTH-1:0] g,
                                                      input logic [WIDTH-1:0] p,
                                                      input logic [KW-1:0]    lvl);
    logic [WIDTH-1:0] low_mask;
    int               d;
    d        = 1 << lvl;
    low_mask = (WIDTH'(1) << d) - WIDTH'(1);
    return {g | (p & (g << d)), p & ((p << d) | low_mask)};
  endfunction

  assign {g_lvl, p_lvl} = prefix_level(g_r, p_r, k);

  assign accept   = (state == IDLE) && in_valid;
  assign last_lvl = (state == EVAL) && (k == KW'(LEVELS - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign gp_err    = gp_err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    if (last_lvl) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture folds Cin into g[0] so the tree yields carries directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      g_r      <= '0;
      p_r      <= '0;
      hsum_r   <= '0;
      cin_r    <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      gp_err_r <= 1'b0;
    end else if (accept) begin
      hsum_r   <= P & ~G;
      g_r      <= G | {{(WIDTH-1){1'b0}}, P[0] & Cin};
      p_r      <= P;
      cin_r    <= Cin;
      k        <= '0;
      gp_err_r <= gp_err_r | (|(G & ~P));
    end else if (state == EVAL) begin
      g_r <= g_lvl;
      p_r <= p_lvl;
      k   <= k + KW'(1);
      if (last_lvl) begin
        k      <= '0;
        sum_r  <= hsum_r ^ {g_lvl[WIDTH-2:0], cin_r};
        cout_r <= g_lvl[WIDTH-1];
      end
    end
  end

endmodule

// File: doc/prefix_postprocess_seq.md
Name: prefix_postprocess_seq

Overview:
- Consumer end of the 16-bit parallel-prefix adder datapath.
- Accepts per-bit generate G = A&B and OR-form propagate P = A|B, plus carry-in, from the G/P preprocess stage.
- Evaluates the Kogge-Stone prefix tree iteratively, one level per clock, then forms Sum and Cout.
- Valid/ready handshakes on both sides; multi-cycle area-reduced alternative to the combinational prefix tree.

Parameters:
- WIDTH, 16, operand width; power of two, minimum 2.
- LEVELS, 4, prefix levels; must equal log2(WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  G/P/Cin presented.
- in_ready  out  1  block can accept an operand set.
- G  in  WIDTH  per-bit generate (A&B).
- P  in  WIDTH  per-bit propagate, OR form (A|B).
- Cin  in  1  carry into bit 0.
- out_valid  out  1  Sum/Cout valid.
- out_ready  in  1  downstream accepts the result.
- Sum  out  WIDTH  sum result.
- Cout  out  1  carry out of bit WIDTH-1.
- gp_err  out  1  sticky flag: an accepted bit had G=1 and P=0.

Behaviour:
- Reset (rst_n=0, async), immediate and regardless of clock:
  - state=IDLE, level counter=0, internal g/p/hsum registers=0.
  - Sum=0, Cout=0, out_valid=0, gp_err=0.
  - in_ready=1 while in IDLE, including during reset.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EVAL: in_ready=0, out_valid=0; counter k=0..LEVELS-1.
  - DONE: in_ready=0, out_valid=1.
- Accept: rising edge with IDLE and in_valid=1 (edge T). Capture:
  - hsum = P & ~G (equals A^B for OR-form P).
  - g = G, except g[0] = G[0] | (P[0]&Cin).
  - p = P.
  - cin_r = Cin.
  - gp_err |= |(G & ~P).
  - Go to EVAL with k=0.
- EVAL: each edge applies level k with distance d = 2^k.
  - For i >= d: g[i] <= g[i] | (p[i] & g[i-d]); p[i] <= p[i] & p[i-d].
  - For i < d: g[i] and p[i] unchanged.
  - k increments.
  - On the edge applying k = LEVELS-1 (edge T+LEVELS):
    - Sum[0] = hsum[0] ^ cin_r.
    - Sum[i] = hsum[i] ^ gfinal[i-1], where gfinal is the post-level-k value.
    - Cout = gfinal[WIDTH-1].
    - Go to DONE.
- Latency: out_valid=1 in the cycle after edge T+LEVELS (T+4 for WIDTH=16).
- DONE:
  - Sum, Cout and out_valid are held stable until out_ready=1.
  - The handshake edge returns to IDLE, clears out_valid and leaves Sum/Cout holding their last values.
  - Minimum initiation interval is LEVELS+2 cycles.
- in_valid outside IDLE is ignored. No accept is possible in the DONE handshake cycle.
- G=1/P=0 bits are not corrected. The formulas are applied as written; only gp_err records the condition.
- gp_err is cleared only by reset.
- All arithmetic is modulo 2^WIDTH; the carry beyond bit WIDTH-1 appears only on Cout.
- Reset mid-EVAL or mid-DONE abandons the operation. No out_valid pulse is produced for it.

Test Plan:
- Basic add: A=0x1234, B=0x4321 (G=0x0220, P=0x5335), Cin=0 -> Sum=0x5555, Cout=0; out_valid rises exactly 4 cycles after the accept edge.
- Full ripple: G=0x0001, P=0xFFFF, Cin=0 -> Sum=0x0000, Cout=1. Carry-in path: G=0x0000, P=0xFFFF, Cin=1 -> Sum=0x0000, Cout=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid, with new in_valid data driven -> Sum/Cout/out_valid stable, in_ready=0, new data not captured. Release -> IDLE next cycle; following accept gives its own correct result.
- Back-to-back with out_ready=1: 10 random operand pairs -> every Sum/Cout matches A+B+Cin; initiation interval exactly 6 cycles.
- Reset mid-op: pulse rst_n low while in EVAL level 2 -> out_valid=0, in_ready=1, Sum=0 asynchronously. Next operation G=0x00FF, P=0x00FF, Cin=0 -> Sum=0x01FE, Cout=0.
- Error flag: G=0x0001, P=0x0000 -> gp_err=1, remains 1 across later legal operations until reset.
